// File: rtl/uart_rx_fsm.sv
// UART receive frame controller: walks start/data/parity/stop bits on the
// oversampled clock, steers the bit sampler and deserializer, and flags framing errors.
module uart_rx_fsm #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  sampled_bit,
  output logic                  dat_samp_en,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  deser_en,
  output logic                  Fill,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam logic [PRESCALE_W-1:0] EDGE_ONE      = PRESCALE_W'(1);
  localparam logic [3:0]            LAST_DATA_BIT = 4'(DATA_WIDTH);

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_acc;
  logic                  frame_start;
  logic                  bit_done;

  assign frame_start = (state == IDLE) && !RX_IN;
  assign bit_done    = (state != IDLE) && (edge_cnt == (prescale_q - EDGE_ONE));

  assign dat_samp_en = (state != IDLE);
  assign Fill        = (state == DATA);

  // NOTE: every always_comb output gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!RX_IN) state_nxt = START;
      end
      START: begin
        if (bit_done) state_nxt = sampled_bit ? IDLE : DATA;
      end
      DATA: begin
        if (bit_done && (bit_cnt == LAST_DATA_BIT)) state_nxt = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_done) state_nxt = STOP;
      end
      STOP: begin
        if (bit_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The start edge itself is edge 0 of the start bit, so counting resumes at 1.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (state == IDLE) begin
      edge_cnt <= RX_IN ? '0 : EDGE_ONE;
      bit_cnt  <= '0;
    end else if (state_nxt == IDLE) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (bit_done) begin
      edge_cnt <= '0;
      bit_cnt  <= bit_cnt + 4'd1;
    end else begin
      edge_cnt <= edge_cnt + EDGE_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prescale_q <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
    end else if (frame_start) begin
      prescale_q <= Prescale;
      par_en_q   <= PAR_EN;
      par_typ_q  <= PAR_TYP;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_acc <= 1'b0;
    end else if (frame_start) begin
      par_acc <= 1'b0;
    end else if ((state == DATA) && bit_done) begin
      par_acc <= par_acc ^ sampled_bit;
    end
  end

  // Error flags persist across IDLE so software can read them after the frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_err <= 1'b0;
      stp_err <= 1'b0;
    end else if (frame_start) begin
      par_err <= 1'b0;
      stp_err <= 1'b0;
    end else if (bit_done) begin
      if (state == PARITY) par_err <= (sampled_bit != (par_acc ^ par_typ_q));
      if (state == STOP)   stp_err <= ~sampled_bit;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      deser_en   <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      deser_en   <= (state == DATA) && bit_done;
      data_valid <= (state == STOP) && bit_done && sampled_bit && !par_err;
    end
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Directed bench for uart_rx_fsm: drives framed bytes with an idealised sampler
// and scoreboards delivered bytes, strobe timing and error flags.
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RX_IN = 1'b1;
  logic [5:0] Prescale = 6'd8;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       sampled_bit = 1'b1;
  logic       dat_samp_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       deser_en;
  logic       Fill;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .Prescale(Prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
    .dat_samp_en(dat_samp_en), .edge_cnt(edge_cnt), .bit_cnt(bit_cnt),
    .deser_en(deser_en), .Fill(Fill), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] outs();
    return {dat_samp_en, edge_cnt, bit_cnt, deser_en, Fill, data_valid, par_err, stp_err};
  endfunction

  // Scoreboard and strobe monitor
  logic [7:0] shreg = '0;
  logic [7:0] exp_q[$];
  int         dv_times[$];
  int         deser_cnt = 0;
  int         dv_cnt = 0;
  int         fill_cnt = 0;

  always @(negedge CLK) begin
    if (deser_en === 1'b1) begin
      shreg = {sampled_bit, shreg[7:1]};
      deser_cnt++;
    end
    if (Fill === 1'b1) fill_cnt++;
    if (data_valid === 1'b1) begin
      dv_cnt++;
      dv_times.push_back(cyc);
      check("sb_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("sb_byte", shreg, exp_q.pop_front());
    end
  end

  // Sampler model: the voted bit becomes valid at edge p/2+2 of each bit period.
  task automatic send_bit(input logic b, input int p);
    RX_IN = b;
    for (int i = 0; i < p; i++) begin
      if (i == p / 2 + 2) sampled_bit = b;
      @(negedge CLK);
    end
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    sampled_bit = 1'b1;
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_frame(input logic [7:0] data, input int p, input logic with_par,
                            input logic par_bit, input logic stop_bit, input logic flip_par_en,
                            output int t0, output logic exp_pe, output logic exp_se);
    logic exp_par;
    Prescale = p[5:0];
    PAR_EN   = with_par;
    exp_par  = (^data) ^ PAR_TYP;
    exp_pe   = with_par && (par_bit != exp_par);
    exp_se   = !stop_bit;
    if (!exp_pe && !exp_se) exp_q.push_back(data);
    t0 = cyc + 1;
    send_bit(1'b0, p);
    for (int k = 0; k < 8; k++) begin
      if (flip_par_en && k == 3) PAR_EN = ~PAR_EN;
      send_bit(data[k], p);
    end
    if (with_par) send_bit(par_bit, p);
    if (flip_par_en) PAR_EN = ~PAR_EN;
    send_bit(stop_bit, p);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   t0, t0b, dv0, ds0, fc0;
    logic pe, se;

    // Power-on reset
    repeat (3) @(negedge CLK);
    check("reset_outs", outs(), 16'h0);
    RST = 1'b1;
    idle(4);

    // Abort mid-DATA with an asynchronous reset
    Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    send_bit(1'b0, 8);
    send_bit(1'b1, 8);
    send_bit(1'b0, 8);
    repeat (3) @(negedge CLK);
    check("mid_fill", Fill, 1'b1);
    check("mid_bit_cnt", bit_cnt, 4'd3);
    check("mid_edge_cnt", edge_cnt, 6'd3);
    check("mid_deser", deser_cnt, 2);
    #2 RST = 1'b0;
    #1 check("rst_async_outs", outs(), 16'h0);
    #1 RST = 1'b1;
    RX_IN = 1'b1; sampled_bit = 1'b1;
    @(negedge CLK);
    idle(30);
    check("rst_quiet_outs", outs(), 16'h0);
    check("rst_quiet_deser", deser_cnt, 2);
    check("rst_quiet_dv", dv_cnt, 0);

    // 0xA5, P=8, no parity
    ds0 = deser_cnt; fc0 = fill_cnt; dv0 = dv_cnt;
    fork
      begin
        @(negedge CLK);
        check("a5_t0_edge_cnt", edge_cnt, 6'd1);
        check("a5_t0_bit_cnt", bit_cnt, 4'd0);
        check("a5_t0_samp_en", dat_samp_en, 1'b1);
        check("a5_start_fill", Fill, 1'b0);
        repeat (8) @(negedge CLK);
        check("a5_data_fill", Fill, 1'b1);
        check("a5_data_bit_cnt", bit_cnt, 4'd1);
        check("a5_data_edge_cnt", edge_cnt, 6'd1);
      end
    join_none
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b0, t0, pe, se);
    idle(3);
    check("a5_deser_pulses", deser_cnt - ds0, 8);
    check("a5_fill_cycles", fill_cnt - fc0, 64);
    check("a5_dv_count", dv_cnt - dv0, 1);
    check("a5_dv_time", dv_times[$], t0 + 79);
    check("a5_par_err", par_err, 1'b0);
    check("a5_stp_err", stp_err, 1'b0);
    check("a5_idle_outs", outs(), 16'h0);

    // Even parity, P=16, 0x3C with correct then wrong parity bit
    PAR_TYP = 1'b0;
    dv0 = dv_cnt;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b0, t0, pe, se);
    idle(3);
    check("even_ok_dv_count", dv_cnt - dv0, 1);
    check("even_ok_dv_time", dv_times[$], t0 + 175);
    check("even_ok_par_err", par_err, pe);
    check("even_ok_stp_err", stp_err, se);
    dv0 = dv_cnt;
    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, 1'b0, t0, pe, se);
    idle(3);
    check("even_bad_dv_count", dv_cnt - dv0, 0);
    check("even_bad_par_err", par_err, pe);
    check("even_bad_stp_err", stp_err, se);

    // Odd parity, P=32, 0x01, stop bit low
    PAR_TYP = 1'b1;
    dv0 = dv_cnt;
    send_frame(8'h01, 32, 1'b1, 1'b0, 1'b0, 1'b0, t0, pe, se);
    idle(3);
    check("odd_stp_dv_count", dv_cnt - dv0, 0);
    check("odd_stp_stp_err", stp_err, se);
    check("odd_stp_par_err", par_err, pe);
    idle(10);
    check("odd_stp_err_held", stp_err, 1'b1);

    // Next frame clears the held stop error at its start edge
    dv0 = dv_cnt;
    fork
      begin
        @(negedge CLK);
        check("clr_stp_err_t0", stp_err, 1'b0);
      end
    join_none
    send_frame(8'h00, 8, 1'b0, 1'b0, 1'b1, 1'b0, t0, pe, se);
    idle(3);
    check("clr_dv_count", dv_cnt - dv0, 1);

    // Start-bit glitch, P=8
    Prescale = 6'd8; PAR_EN = 1'b0;
    dv0 = dv_cnt; ds0 = deser_cnt;
    t0 = cyc + 1;
    RX_IN = 1'b0;
    repeat (3) @(negedge CLK);
    RX_IN = 1'b1;
    repeat (4) @(negedge CLK);
    check("glitch_busy_at_edge7", dat_samp_en, 1'b1);
    @(negedge CLK);
    check("glitch_idle_after_edge8", dat_samp_en, 1'b0);
    idle(10);
    check("glitch_outs", outs(), 16'h0);
    check("glitch_deser", deser_cnt - ds0, 0);
    check("glitch_dv", dv_cnt - dv0, 0);

    // Back-to-back 0x55 / 0xFF, PAR_EN toggled during the first frame
    PAR_TYP = 1'b0;
    dv0 = dv_cnt;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, 1'b1, t0, pe, se);
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b1, 1'b0, t0b, pe, se);
    idle(3);
    check("b2b_dv_count", dv_cnt - dv0, 2);
    check("b2b_first_time", dv_times[$-1], t0 + 79);
    check("b2b_spacing", dv_times[$] - dv_times[$-1], 80);
    check("b2b_par_err", par_err, 1'b0);
    check("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
Receive-side frame controller for the UART RX path. It tracks start, data, optional parity and stop bits from the oversampled RX line. It drives the bit sampler's enable and edge/bit counters, and drives the deserializer's deser_en/Fill/data_valid strobes. Parity and stop-bit checks happen here; data_valid is suppressed on any framing error.

Parameters:
DATA_WIDTH, 8, data bits per frame (deserializer fixed at 8)
PRESCALE_W, 6, width of Prescale and edge_cnt

Ports:
CLK  input  1  RX oversampling clock
RST  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high
Prescale  input  6  oversampling ratio; legal 8, 16, 32
PAR_EN  input  1  1 = parity bit present
PAR_TYP  input  1  0 = even, 1 = odd
sampled_bit  input  1  majority-voted bit from sampler, stable from edge_cnt = Prescale/2+2 to end of bit
dat_samp_en  output  1  sampler enable
edge_cnt  output  6  oversample edge index within current bit
bit_cnt  output  4  frame bit index (start = 0)
deser_en  output  1  one-cycle strobe: shift sampled_bit into deserializer
Fill  output  1  high throughout DATA state
data_valid  output  1  one-cycle strobe: byte complete and error-free
par_err  output  1  parity error of last frame
stp_err  output  1  stop-bit error of last frame

Behaviour:
- Clock and reset: one clock, CLK. Reset RST is asynchronous, active-low. Reset forces state IDLE and drives every output and counter to 0.
- States: IDLE, START, DATA, PARITY, STOP. State register is binary-encoded.
- IDLE:
  - edge_cnt = 0, bit_cnt = 0, dat_samp_en = 0.
  - RX_IN sampled 0 at edge T0 -> START.
  - At T0, latch Prescale, PAR_EN and PAR_TYP into frame registers. Changes to these inputs mid-frame are ignored.
  - At T0, clear par_err, stp_err and the parity accumulator.
- Counters:
  - In every non-IDLE state, edge_cnt increments each cycle.
  - At edge_cnt = P-1 (P = latched Prescale), edge_cnt wraps to 0 and bit_cnt increments.
  - The decision edge for frame bit k is edge_cnt = P-1 with bit_cnt = k. It occurs (k+1)*P-1 edges after T0.
- dat_samp_en = 1 in all non-IDLE states.
- START: at the decision edge, sampled_bit = 0 -> DATA. sampled_bit = 1 -> IDLE as a glitch, with no strobes and no error flags.
- DATA:
  - Fill = 1.
  - deser_en is high for exactly the one cycle following each data-bit decision edge (bit_cnt 1..8). That is 8 pulses per frame, LSB first.
  - The parity accumulator XORs each sampled_bit at its decision edge.
  - After bit_cnt = 8 decision: go to PARITY if PAR_EN, else STOP.
  - Fill drops with the state change.
- PARITY: at the decision edge, expected = acc (even) or ~acc (odd). par_err <= (sampled_bit != expected). Then -> STOP.
- STOP:
  - At the decision edge, stp_err <= ~sampled_bit.
  - data_valid is high for the one following cycle iff neither error is set for this frame.
  - State -> IDLE; counters cleared.
- Error flags are registered and held until the next T0.
- Back-to-back frames: RX_IN = 0 in the first IDLE cycle after STOP starts a new frame with no dead cycle.
- Frame length (edges T0 -> stop decision): 10P-1 without parity, 11P-1 with parity.
- Reset mid-frame aborts immediately: no data_valid, flags 0.
- Prescale values other than 8/16/32 are outside contract.

Test Plan:
- Reset: drive RST low mid-frame (P=8, DATA state) -> all outputs 0 asynchronously, state IDLE. After release with RX_IN = 1, nothing toggles.
- No parity, P=8, byte 0xA5:
  - Exactly 8 deser_en pulses, delivering bits 1,0,1,0,0,1,0,1.
  - Fill high only in DATA.
  - data_valid pulses once, on the cycle after edge T0+79; par_err = stp_err = 0.
- Even parity, P=16, byte 0x3C, parity bit 0 -> data_valid once, par_err = 0. Repeat with parity bit 1 -> par_err = 1, no data_valid.
- Odd parity, P=32, byte 0x01, stop bit driven 0 -> stp_err = 1, par_err = 0, no data_valid. Next frame clears stp_err at its T0.
- Glitch: RX_IN low for 3 cycles then high, P=8 -> return to IDLE after 8 edges. No deser_en, no data_valid, no error flags.
- Back-to-back: two frames 0x55 then 0xFF with zero idle gap, P=8, no parity. Change PAR_EN to 1 during the first frame -> two data_valid pulses exactly 80 cycles apart. The first frame ignores the PAR_EN change.
